// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer
// and the flow-control FSM that consumes its stall/done pair.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } state_e;

    typedef enum logic {
        NORMAL = 1'b0,
        MULDIV = 1'b1
    } flow_e;

    typedef enum logic [1:0] {
        COND_NONE  = 2'b00,
        COND_STALL = 2'b01,
        COND_FLUSH = 2'b10,
        COND_OVER  = 2'b11
    } cond_e;

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 iterative datapath: shift-add multiply and
// restoring shift-subtract divide on unsigned magnitudes.
module muldiv_core
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               div_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   m_q;
    logic               div_q;

    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH:0]     x;
    logic [WIDTH:0]     y;
    logic [WIDTH+1:0]   sum;
    logic               qbit;
    logic [WIDTH-1:0]   rem_nx;

    assign hi = acc_q[2*WIDTH-1:WIDTH];
    assign lo = acc_q[WIDTH-1:0];

    // Divide subtracts via inverted operand plus carry-in; carry-out is the quotient bit.
    assign x   = div_q ? {hi, lo[WIDTH-1]} : {1'b0, hi};
    assign y   = div_q ? ~{1'b0, m_q} : (lo[0] ? {1'b0, m_q} : '0);
    assign sum = {1'b0, x} + {1'b0, y} + {{(WIDTH+1){1'b0}}, div_q};

    assign qbit   = sum[WIDTH+1];
    assign rem_nx = qbit ? sum[WIDTH-1:0] : x[WIDTH-1:0];

    always_comb begin
        acc_d = acc_q;
        if (div_q) begin
            acc_d = {rem_nx, lo[WIDTH-2:0], qbit};
        end else begin
            acc_d = {sum[WIDTH:0], lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            m_q   <= '0;
            div_q <= 1'b0;
        end else if (load_i) begin
            div_q <= div_i;
            m_q   <= div_i ? b_i : a_i;
            acc_q <= div_i ? {{WIDTH{1'b0}}, a_i} : {{WIDTH{1'b0}}, b_i};
        end else if (step_i) begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage MULT/MULTU/DIV/DIVU controller: FSM, sign fix-up,
// HI/LO ownership and stall/done handshake to flow control.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             done_o,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_zero_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic               div_q;
    logic               neg_res_q;
    logic               neg_rem_q;
    logic               bz_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               div_zero_q;

    logic               accept;
    logic               sgn_in;
    logic               div_in;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;

    assign accept = (state_q == S_IDLE) && start_i && !cancel_i;
    assign sgn_in = (op_i == OP_MULT) || (op_i == OP_DIV);
    assign div_in = (op_i == OP_DIV) || (op_i == OP_DIVU);
    assign a_mag  = (sgn_in && a_i[WIDTH-1]) ? -a_i : a_i;
    assign b_mag  = (sgn_in && b_i[WIDTH-1]) ? -b_i : b_i;

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load_i (accept),
        .step_i (state_q == S_CALC),
        .div_i  (div_in),
        .a_i    (a_mag),
        .b_i    (b_mag),
        .acc_o  (acc)
    );

    assign prod = neg_res_q ? -acc : acc;
    assign quo  = acc[WIDTH-1:0];
    assign rem  = acc[2*WIDTH-1:WIDTH];

    always_comb begin
        hi_d = prod[2*WIDTH-1:WIDTH];
        lo_d = prod[WIDTH-1:0];
        if (div_q) begin
            if (bz_q) begin
                lo_d = '1;
                hi_d = a_raw_q;
            end else begin
                lo_d = neg_res_q ? -quo : quo;
                hi_d = neg_rem_q ? -rem : rem;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            bz_q       <= 1'b0;
            a_raw_q    <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q    <= S_CALC;
                        cnt_q      <= '0;
                        div_q      <= div_in;
                        neg_res_q  <= sgn_in && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        neg_rem_q  <= sgn_in && a_i[WIDTH-1];
                        bz_q       <= (b_i == '0);
                        a_raw_q    <= a_i;
                        div_zero_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (cancel_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (cancel_i) begin
                        state_q <= S_IDLE;
                    end else begin
                        state_q    <= S_DONE;
                        hi_q       <= hi_d;
                        lo_q       <= lo_d;
                        div_zero_q <= div_q && bz_q;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stall drops in DONE so the pipeline advances in the same cycle as done.
    assign busy_o     = (state_q == S_CALC) || (state_q == S_FIX);
    assign stall_o    = accept || busy_o;
    assign done_o     = (state_q == S_DONE);
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;
    assign div_zero_o = div_zero_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed plus random stimulus for muldiv_sequencer, checked
// against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        cancel_i = 1'b0;
    logic        stall_o;
    logic        done_o;
    logic        busy_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_zero_o;

    int total = 0;
    int bad = 0;

    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    logic        exp_dz = 1'b0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .cancel_i   (cancel_i),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .busy_o     (busy_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .div_zero_o (div_zero_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] h,
                                  output logic [31:0] l, output logic dz);
        longint sa;
        longint sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = 1'b0;
        case (op)
            2'b00: p = 64'(sa * sb);
            2'b01: p = {32'h0, a} * {32'h0, b};
            default: p = '0;
        endcase
        h = p[63:32];
        l = p[31:0];
        if (op[1]) begin
            if (b == 0) begin
                l = 32'hFFFF_FFFF;
                h = a;
                dz = 1'b1;
            end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                l = 32'h8000_0000;
                h = 32'h0;
            end else if (op == 2'b10) begin
                l = 32'(sa / sb);
                h = 32'(sa % sb);
            end else begin
                l = a / b;
                h = a % b;
            end
        end
    endfunction

    // Issues one op in the current IDLE cycle and follows it to its DONE cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic [31:0] eh;
        logic [31:0] el;
        logic ed;
        int done_at;
        int win_err;
        model(op, a, b, eh, el, ed);
        @(negedge clk);
        start_i = 1'b1;
        op_i = op;
        a_i = a;
        b_i = b;
        #1 check("stall_c0", stall_o, 1);
        @(negedge clk);
        start_i = 1'b0;
        done_at = 0;
        win_err = 0;
        for (int c = 1; c <= 34; c++) begin
            if (c > 1) @(negedge clk);
            if (done_o === 1'b1 && done_at == 0) done_at = c;
            if (stall_o !== (c < 34)) win_err++;
            if (busy_o !== (c <= 33)) win_err++;
        end
        check("done_cycle", done_at, 34);
        check("stall_busy_window", win_err, 0);
        check("hi", hi_o, eh);
        check("lo", lo_o, el);
        check("div_zero", div_zero_o, ed);
        exp_hi = eh;
        exp_lo = el;
        exp_dz = ed;
    endtask

    initial begin
        int dones;
        logic [1:0] rop;
        logic [31:0] ra;
        logic [31:0] rb;

        @(negedge clk);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        check("rst_done", done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_dz", div_zero_o, 0);
        rst = 1'b0;

        do_op(2'b00, 32'hFFFF_FFFD, 32'd7);
        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        do_op(2'b11, 32'd7, 32'd2);
        do_op(2'b10, 32'd5, 32'd0);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'b11, 32'hDEAD_BEEF, 32'd0);
        do_op(2'b00, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 16; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 4))
                0: rb = '0;
                1: rb = 32'($urandom_range(1, 15));
                2: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: rb = $urandom;
            endcase
            do_op(rop, ra, rb);
        end

        // Cancel during cycle 10 of a divide.
        @(negedge clk);
        start_i = 1'b1;
        op_i = 2'b10;
        a_i = 32'd100;
        b_i = 32'd3;
        @(negedge clk);
        start_i = 1'b0;
        repeat (9) @(negedge clk);
        cancel_i = 1'b1;
        @(negedge clk);
        cancel_i = 1'b0;
        check("cancel_stall", stall_o, 0);
        check("cancel_busy", busy_o, 0);
        exp_dz = 1'b0;
        dones = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done_o === 1'b1) dones++;
        end
        check("cancel_no_done", dones, 0);
        check("cancel_hi", hi_o, exp_hi);
        check("cancel_lo", lo_o, exp_lo);
        check("cancel_dz", div_zero_o, exp_dz);

        // Start and cancel in the same IDLE cycle.
        @(negedge clk);
        start_i = 1'b1;
        cancel_i = 1'b1;
        op_i = 2'b01;
        a_i = 32'd3;
        b_i = 32'd4;
        #1 check("sc_stall", stall_o, 0);
        @(negedge clk);
        start_i = 1'b0;
        cancel_i = 1'b0;
        check("sc_busy", busy_o, 0);
        dones = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (done_o === 1'b1 || busy_o === 1'b1) dones++;
        end
        check("sc_idle", dones, 0);
        check("sc_lo", lo_o, exp_lo);

        do_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0);
        do_op(2'b11, 32'd9, 32'd0);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start_i = 1'b1;
        op_i = 2'b00;
        a_i = 32'd11;
        b_i = 32'd13;
        @(negedge clk);
        start_i = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_busy", busy_o, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_hi", hi_o, 0);
        check("arst_lo", lo_o, 0);
        check("arst_busy", busy_o, 0);
        check("arst_stall", stall_o, 0);
        check("arst_done", done_o, 0);
        check("arst_dz", div_zero_o, 0);
        @(negedge clk);
        rst = 1'b0;

        do_op(2'b10, 32'd100, 32'hFFFF_FFFD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
